// File: rtl/mem_store_buffer_if.sv
// Request/response bundle between the MEM stage and the store buffer.
//   master : MEM stage side (drives requests, receives ready and load responses)
//   slave  : store buffer side
// Signals:
//   req_valid/req_ready  request handshake, transfer when both are high at posedge
//   req_we               1 = store, 0 = load
//   req_addr             memory word address
//   req_wdata            store data (ignored for loads)
//   resp_valid           one-cycle pulse, load data valid
//   resp_data            load result, held until the next load response
interface mem_store_buffer_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          resp_valid;
  logic [DW-1:0] resp_data;

  modport master (output req_valid, req_we, req_addr, req_wdata,
                  input  req_ready, resp_valid, resp_data);
  modport slave  (input  req_valid, req_we, req_addr, req_wdata,
                  output req_ready, resp_valid, resp_data);
endinterface

// File: rtl/mem_store_buffer.sv
// Memory-access front end in front of the data memory. Stores are queued in an
// in-order FIFO and drained one per free memory cycle; loads are issued with a
// fixed two-cycle response latency and take priority over the drain.
//
// Optional feature macro: STORE_FWD_EN
//   defined   : loads search the FIFO; a hit returns the youngest matching data
//               without a memory read, a miss reads memory ahead of queued stores.
//   undefined : a load waits (req_ready=0) until the FIFO is empty.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   bus         request/response interface (slave modport)
//   sb_empty_o  FIFO empty and no load in flight
//   daddr_o     memory word address (registered)
//   data_in_o   memory write data (registered)
//   rd_o        memory read strobe, active low
//   wr_o        memory write strobe, active low (memory samples on negedge)
//   data_out_i  memory read data, combinational from daddr_o
module mem_store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  mem_store_buffer_if.slave bus,
  output logic            sb_empty_o,
  output logic [AW-1:0]   daddr_o,
  output logic [DW-1:0]   data_in_o,
  output logic            rd_o,
  output logic            wr_o,
  input  logic [DW-1:0]   data_out_i
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] addr_mem_q [DEPTH];
  logic [DW-1:0] data_mem_q [DEPTH];
  logic [PW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q, count_d;
  logic          en_q, rd_q, wr_q, resp_valid_q, fwd_v_q;
  logic [AW-1:0] daddr_q;
  logic [DW-1:0] data_in_q, resp_data_q, fwd_data_q;

  logic          full, in_flight, load_ok, hit;
  logic [DW-1:0] hit_data;
  logic          push, load_acc, ld_mem, pop;

  assign full      = (count_q == CW'(DEPTH));
  // A load is in flight from the cycle after acceptance until its response.
  assign in_flight = !rd_q || fwd_v_q;

`ifdef STORE_FWD_EN
  // Scan oldest to youngest so the last match (youngest) wins.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < count_q) && (addr_mem_q[head_q + PW'(i)] == bus.req_addr)) begin
        hit      = 1'b1;
        hit_data = data_mem_q[head_q + PW'(i)];
      end
    end
  end
  assign load_ok = !in_flight;
`else
  assign hit      = 1'b0;
  assign hit_data = '0;
  assign load_ok  = !in_flight && (count_q == '0);
`endif

  assign bus.req_ready = en_q && (bus.req_we ? !full : load_ok);
  assign push          = bus.req_valid && bus.req_ready && bus.req_we;
  assign load_acc      = bus.req_valid && bus.req_ready && !bus.req_we;
  assign ld_mem        = load_acc && !hit;
  // The port cycle after this edge belongs to a memory load if one is issued.
  assign pop           = (count_q != '0) && !ld_mem;

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      en_q         <= 1'b0;
      rd_q         <= 1'b1;
      wr_q         <= 1'b1;
      daddr_q      <= '0;
      data_in_q    <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      fwd_v_q      <= 1'b0;
      fwd_data_q   <= '0;
    end else begin
      en_q    <= 1'b1;
      count_q <= count_d;
      if (push) tail_q <= tail_q + PW'(1);
      if (pop)  head_q <= head_q + PW'(1);
      rd_q <= !ld_mem;
      wr_q <= !pop;
      if (ld_mem) begin
        daddr_q <= bus.req_addr;
      end else if (pop) begin
        daddr_q   <= addr_mem_q[head_q];
        data_in_q <= data_mem_q[head_q];
      end
      fwd_v_q <= load_acc && hit;
      if (load_acc && hit) fwd_data_q <= hit_data;
      resp_valid_q <= in_flight;
      if (!rd_q)        resp_data_q <= data_out_i;
      else if (fwd_v_q) resp_data_q <= fwd_data_q;
    end
  end

  // Storage needs no reset: entries are only read when covered by count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem_q[tail_q] <= bus.req_addr;
      data_mem_q[tail_q] <= bus.req_wdata;
    end
  end

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;
  assign sb_empty_o     = (count_q == '0) && !in_flight;
  assign daddr_o        = daddr_q;
  assign data_in_o      = data_in_q;
  assign rd_o           = rd_q;
  assign wr_o           = wr_q;
endmodule

// File: tb/tb_mem_store_buffer.sv
module tb_mem_store_buffer;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  mem_store_buffer_if #(.AW(AW), .DW(DW)) bus ();
  logic          sb_empty, rd, wr;
  logic [AW-1:0] daddr;
  logic [DW-1:0] din, dout;

  mem_store_buffer #(.DEPTH(4), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .sb_empty_o(sb_empty),
    .daddr_o(daddr), .data_in_o(din), .rd_o(rd), .wr_o(wr), .data_out_i(dout)
  );

  // Memory model: unwritten words read as 0xA0000000 | addr.
  logic [DW-1:0] mem [0:63];
  bit   [63:0]   written;
  int            ev_q[$];        // write: addr, read: 1000+addr
  int            collisions = 0;
  assign dout = written[daddr[5:0]] ? mem[daddr[5:0]] : (32'hA000_0000 | {26'd0, daddr[5:0]});

  always @(negedge clk) begin
    if (rd === 1'b0 && wr === 1'b0) collisions++;
    if (wr === 1'b0) begin
      mem[daddr[5:0]] = din;
      written[daddr[5:0]] = 1'b1;
      ev_q.push_back(int'(daddr[5:0]));
    end
    if (rd === 1'b0) ev_q.push_back(1000 + int'(daddr[5:0]));
  end

  int total = 0;
  int passed = 0;

  task automatic send(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      output int tries);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = a; bus.req_wdata = d;
    tries = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (bus.req_ready === 1'b1) begin tries = n; break; end
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic test_reset();
    bus.req_valid = 0; bus.req_we = 1; bus.req_addr = 0; bus.req_wdata = 0;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk); #1;
    total++; if (bus.req_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", bus.req_ready); else passed++;
    total++; if (bus.resp_valid !== 1'b0) $display("FAIL reset_resp_valid: got %b want 0", bus.resp_valid); else passed++;
    total++; if (bus.resp_data !== 32'd0) $display("FAIL reset_resp_data: got %h want 0", bus.resp_data); else passed++;
    total++; if (sb_empty !== 1'b1) $display("FAIL reset_sb_empty: got %b want 1", sb_empty); else passed++;
    total++; if (daddr !== 32'd0) $display("FAIL reset_daddr: got %h want 0", daddr); else passed++;
    total++; if (din !== 32'd0) $display("FAIL reset_datain: got %h want 0", din); else passed++;
    total++; if (rd !== 1'b1) $display("FAIL reset_rd: got %b want 1", rd); else passed++;
    total++; if (wr !== 1'b1) $display("FAIL reset_wr: got %b want 1", wr); else passed++;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (bus.req_ready !== 1'b1) $display("FAIL ready_after_release: got %b want 1", bus.req_ready); else passed++;
  endtask

  task automatic test_store_load();
    int tr; bit found;
    send(1'b1, 32'd5, 32'h1122_3344, tr);
    total++; if (tr != 1) $display("FAIL st5_accept: tries %0d want 1", tr); else passed++;
    found = 0;
    for (int n = 0; n < 3 && !found; n++) begin
      if (wr === 1'b0) found = 1; else begin @(posedge clk); #1; end
    end
    total++; if (!found) $display("FAIL st5_wr_pulse: got none want WR=0 within 2 cycles"); else passed++;
    total++; if (daddr !== 32'd5) $display("FAIL st5_daddr: got %h want 5", daddr); else passed++;
    total++; if (din !== 32'h1122_3344) $display("FAIL st5_datain: got %h want 11223344", din); else passed++;
    total++; if (rd !== 1'b1) $display("FAIL st5_rd: got %b want 1", rd); else passed++;
    @(posedge clk); #1;
    total++; if (wr !== 1'b1) $display("FAIL st5_wr_one_cycle: got %b want 1", wr); else passed++;
    send(1'b0, 32'd5, 32'd0, tr);
    total++; if (rd !== 1'b0 || daddr !== 32'd5) $display("FAIL ld5_issue: got rd=%b addr=%h want rd=0 addr=5", rd, daddr); else passed++;
    @(posedge clk); #1;
    total++; if (bus.resp_valid !== 1'b1) $display("FAIL ld5_resp_valid: got %b want 1", bus.resp_valid); else passed++;
    total++; if (bus.resp_data !== 32'h1122_3344) $display("FAIL ld5_data: got %h want 11223344", bus.resp_data); else passed++;
    total++; if (sb_empty !== 1'b1) $display("FAIL ld5_sb_empty: got %b want 1", sb_empty); else passed++;
    @(posedge clk); #1;
    total++; if (bus.resp_valid !== 1'b0) $display("FAIL ld5_resp_pulse: got %b want 0", bus.resp_valid); else passed++;
  endtask

  task automatic test_forward();
    int tr, n;
    send(1'b1, 32'd7, 32'hAAAA_0000, tr);
    send(1'b0, 32'd7, 32'd0, tr);
`ifdef STORE_FWD_EN
    total++; if (tr != 1) $display("FAIL fwd7_accept: tries %0d want 1", tr); else passed++;
    total++; if (rd !== 1'b1) $display("FAIL fwd7_no_read: got rd=%b want 1", rd); else passed++;
    total++; if (wr !== 1'b0 || daddr !== 32'd7) $display("FAIL fwd7_drain: got wr=%b addr=%h want wr=0 addr=7", wr, daddr); else passed++;
    @(posedge clk); #1;
    total++; if (rd !== 1'b1) $display("FAIL fwd7_no_read2: got rd=%b want 1", rd); else passed++;
`else
    total++; if (tr != 2) $display("FAIL ld7_stall: tries %0d want 2", tr); else passed++;
    total++; if (rd !== 1'b0 || daddr !== 32'd7) $display("FAIL ld7_issue: got rd=%b addr=%h want rd=0 addr=7", rd, daddr); else passed++;
    @(posedge clk); #1;
    n = ev_q.size();
    total++; if (n < 2 || ev_q[n-2] != 7 || ev_q[n-1] != 1007) $display("FAIL ld7_order: got size %0d want write 7 then read 7", n); else passed++;
`endif
    total++; if (bus.resp_valid !== 1'b1) $display("FAIL ld7_resp_valid: got %b want 1", bus.resp_valid); else passed++;
    total++; if (bus.resp_data !== 32'hAAAA_0000) $display("FAIL ld7_data: got %h want aaaa0000", bus.resp_data); else passed++;
  endtask

  task automatic test_same_addr();
    int tr; bit found;
    send(1'b1, 32'd9, 32'd1, tr);
    send(1'b1, 32'd9, 32'd2, tr);
    send(1'b0, 32'd9, 32'd0, tr);
    found = 0;
    for (int n = 0; n < 5 && !found; n++) begin
      if (bus.resp_valid === 1'b1) found = 1; else begin @(posedge clk); #1; end
    end
    total++; if (!found) $display("FAIL ld9_resp: got no response want one"); else passed++;
    total++; if (bus.resp_data !== 32'd2) $display("FAIL ld9_youngest: got %h want 2", bus.resp_data); else passed++;
  endtask

  task automatic test_priority();
    int tr, base;
    base = ev_q.size();
    send(1'b1, 32'd20, 32'hDEAD_BEEF, tr);
    send(1'b0, 32'd3, 32'd0, tr);
    total++; if (rd !== 1'b0 || wr !== 1'b1 || daddr !== 32'd3) $display("FAIL prio_rd_cycle: got rd=%b wr=%b addr=%h want rd=0 wr=1 addr=3", rd, wr, daddr); else passed++;
    @(posedge clk); #1;
`ifdef STORE_FWD_EN
    total++; if (wr !== 1'b0 || daddr !== 32'd20) $display("FAIL prio_drain_next: got wr=%b addr=%h want wr=0 addr=14", wr, daddr); else passed++;
`endif
    total++; if (bus.resp_valid !== 1'b1 || bus.resp_data !== 32'hA000_0003) $display("FAIL prio_ld3_data: got v=%b d=%h want v=1 d=a0000003", bus.resp_valid, bus.resp_data); else passed++;
    @(posedge clk); #1;
    if (ev_q.size() < base + 2) begin
      total++; $display("FAIL prio_order: got %0d events want 2", ev_q.size() - base);
    end else begin
`ifdef STORE_FWD_EN
      total++; if (ev_q[base] != 1003 || ev_q[base+1] != 20) $display("FAIL prio_order: got %0d,%0d want 1003,20", ev_q[base], ev_q[base+1]); else passed++;
`else
      total++; if (ev_q[base] != 20 || ev_q[base+1] != 1003) $display("FAIL prio_order: got %0d,%0d want 20,1003", ev_q[base], ev_q[base+1]); else passed++;
`endif
    end
    total++; if (mem[20] !== 32'hDEAD_BEEF) $display("FAIL prio_mem20: got %h want deadbeef", mem[20]); else passed++;
  endtask

  task automatic test_back_to_back();
    int tr, base, got;
    base = ev_q.size();
    for (int i = 0; i < 5; i++) begin
      send(1'b1, i, 32'h100 + i, tr);
      total++; if (tr != 1) $display("FAIL b2b_ready_%0d: tries %0d want 1", i, tr); else passed++;
    end
    repeat (4) @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      got = (base + i < ev_q.size()) ? ev_q[base+i] : -1;
      total++; if (got != i || mem[i] !== 32'h100 + i) $display("FAIL b2b_write_%0d: got addr %0d data %h want addr %0d data %h", i, got, mem[i], i, 32'h100 + i); else passed++;
    end
    total++; if (ev_q.size() != base + 5) $display("FAIL b2b_count: got %0d writes want 5", ev_q.size() - base); else passed++;
    total++; if (sb_empty !== 1'b1) $display("FAIL b2b_sb_empty: got %b want 1", sb_empty); else passed++;
  endtask

  task automatic test_reset_mid();
    int tr;
    send(1'b1, 32'd30, 32'h30, tr);
    send(1'b1, 32'd31, 32'h31, tr);
    send(1'b1, 32'd32, 32'h32, tr);
    total++; if (wr !== 1'b0 || daddr !== 32'd31) $display("FAIL mid_pre: got wr=%b addr=%h want wr=0 addr=1f", wr, daddr); else passed++;
    rst_n = 1'b0;
    #1;
    total++; if (wr !== 1'b1 || rd !== 1'b1) $display("FAIL mid_strobes: got rd=%b wr=%b want 1 1", rd, wr); else passed++;
    total++; if (daddr !== 32'd0 || din !== 32'd0) $display("FAIL mid_bus: got addr=%h data=%h want 0 0", daddr, din); else passed++;
    total++; if (bus.req_ready !== 1'b0 || sb_empty !== 1'b1) $display("FAIL mid_ctrl: got ready=%b empty=%b want 0 1", bus.req_ready, sb_empty); else passed++;
    total++; if (bus.resp_valid !== 1'b0 || bus.resp_data !== 32'd0) $display("FAIL mid_resp: got v=%b d=%h want 0 0", bus.resp_valid, bus.resp_data); else passed++;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    repeat (6) @(posedge clk); #1;
    total++; if (written[31] || written[32]) $display("FAIL mid_discard: got w31=%b w32=%b want 0 0", written[31], written[32]); else passed++;
    total++; if (mem[30] !== 32'h30) $display("FAIL mid_drained30: got %h want 30", mem[30]); else passed++;
    total++; if (sb_empty !== 1'b1 || wr !== 1'b1) $display("FAIL mid_idle: got empty=%b wr=%b want 1 1", sb_empty, wr); else passed++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_store_load();
    test_forward();
    test_same_addr();
    test_priority();
    test_back_to_back();
    test_reset_mid();
    total++; if (collisions != 0) $display("FAIL strobe_exclusive: got %0d cycles with RD=WR=0 want 0", collisions); else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
